// File: rtl/z80_io_pkg.sv
// Shared types and limits for the Z80-style I/O cycle controller.
package z80_io_pkg;
  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} io_state_t;
  localparam int IO_WAIT_MAX = 7;
endpackage

// File: rtl/z80_io_ctrl.sv
// Z80-style I/O cycle sequencer: T1/T2/TW.../T3 with registered bus outputs,
// automatic wait states plus peripheral WAIT_L stretching.
module z80_io_ctrl
  import z80_io_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] port_addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic        addr_oe,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  input  logic        WAIT_L
);
  localparam int WS = (WAIT_STATES > IO_WAIT_MAX) ? IO_WAIT_MAX :
                      (WAIT_STATES < 1) ? 1 : WAIT_STATES;
  localparam logic [2:0] CNT_LOAD = 3'(WS - 1);

  io_state_t   state, state_nx;
  logic [2:0]  cnt;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        leave_tw;
  logic        cur_we;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic        iorq_nx, rd_nx, wr_nx, aoe_nx, doe_nx, done_nx;
  logic [15:0] addr_nx;
  logic [7:0]  dout_nx;

  assign ack      = (state == IDLE) && req;
  assign busy     = (state != IDLE);
  assign leave_tw = (state == TW) && (cnt == 3'd0) && WAIT_L;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = T1;
      T1:      state_nx = T2;
      T2:      state_nx = TW;
      TW:      if (leave_tw) state_nx = T3;
      T3:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered;
  // on accept the latch is not yet loaded, so take the request inputs directly.
  assign cur_we    = ack ? we        : lat_we;
  assign cur_addr  = ack ? port_addr : lat_addr;
  assign cur_wdata = ack ? wdata     : lat_wdata;

  always_comb begin
    iorq_nx = 1'b1;
    rd_nx   = 1'b1;
    wr_nx   = 1'b1;
    aoe_nx  = 1'b0;
    doe_nx  = 1'b0;
    done_nx = 1'b0;
    addr_nx = 16'h0000;
    dout_nx = 8'h00;
    case (state_nx)
      T1, T2, TW, T3: begin
        aoe_nx  = 1'b1;
        addr_nx = cur_addr;
        doe_nx  = cur_we;
        dout_nx = cur_wdata;
        done_nx = (state_nx == T3);
        if (state_nx == T2 || state_nx == TW) begin
          iorq_nx = 1'b0;
          rd_nx   = cur_we;
          wr_nx   = !cur_we;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 8'h00;
      cnt       <= 3'd0;
      rdata     <= 8'h00;
      IORQ_L    <= 1'b1;
      RD_L      <= 1'b1;
      WR_L      <= 1'b1;
      addr_oe   <= 1'b0;
      data_oe   <= 1'b0;
      done      <= 1'b0;
      addr_out  <= 16'h0000;
      data_out  <= 8'h00;
    end else begin
      if (ack) begin
        lat_we    <= we;
        lat_addr  <= port_addr;
        lat_wdata <= wdata;
      end
      if (state == T2)                       cnt <= CNT_LOAD;
      else if (state == TW && cnt != 3'd0)   cnt <= cnt - 3'd1;
      if (leave_tw && !lat_we)               rdata <= data_in;
      IORQ_L   <= iorq_nx;
      RD_L     <= rd_nx;
      WR_L     <= wr_nx;
      addr_oe  <= aoe_nx;
      data_oe  <= doe_nx;
      done     <= done_nx;
      addr_out <= addr_nx;
      data_out <= dout_nx;
    end
  end
endmodule

// File: tb/tb_z80_io_ctrl.sv
// Bench for z80_io_ctrl: two instances (1 and 3 wait states), transaction-level
// reference model checked every cycle, plus directed literal scenarios.
module tb_z80_io_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req[2], we[2], WAIT_L[2];
  logic [15:0] port_addr[2];
  logic [7:0]  wdata[2], data_in[2];
  logic        ack[2], done[2], busy[2], addr_oe[2], data_oe[2];
  logic        IORQ_L[2], RD_L[2], WR_L[2];
  logic [7:0]  rdata[2], data_out[2];
  logic [15:0] addr_out[2];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  z80_io_ctrl #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .port_addr(port_addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .done(done[0]), .rdata(rdata[0]), .busy(busy[0]),
    .addr_out(addr_out[0]), .addr_oe(addr_oe[0]), .data_out(data_out[0]),
    .data_oe(data_oe[0]), .data_in(data_in[0]), .IORQ_L(IORQ_L[0]), .RD_L(RD_L[0]),
    .WR_L(WR_L[0]), .WAIT_L(WAIT_L[0]));

  z80_io_ctrl #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .port_addr(port_addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .done(done[1]), .rdata(rdata[1]), .busy(busy[1]),
    .addr_out(addr_out[1]), .addr_oe(addr_oe[1]), .data_out(data_out[1]),
    .data_oe(data_oe[1]), .data_in(data_in[1]), .IORQ_L(IORQ_L[1]), .RD_L(RD_L[1]),
    .WR_L(WR_L[1]), .WAIT_L(WAIT_L[1]));

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is "age" cycles old; cycle 1 drives the
  // address only, later cycles strobe until the wait rule releases, then one finish cycle.
  int          ws_of[2] = '{1, 3};
  bit          m_act[2], m_fin[2], m_we[2];
  int          m_age[2], m_tw[2];
  logic [15:0] m_addr[2];
  logic [7:0]  m_wd[2];
  logic [7:0]  m_rd[2] = '{8'h00, 8'h00};
  bit          e_ack, e_done, e_busy, e_aoe, e_doe, e_io, e_rd, e_wr, strobe;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        e_ack  = !m_act[i] && req[i];
        e_busy = m_act[i];
        e_done = m_act[i] && m_fin[i];
        e_aoe  = m_act[i];
        e_doe  = m_act[i] && m_we[i];
        strobe = m_act[i] && m_age[i] >= 2 && !m_fin[i];
        e_io   = !strobe;
        e_rd   = !(strobe && !m_we[i]);
        e_wr   = !(strobe && m_we[i]);
        chk("ack", i, ack[i], e_ack);
        chk("done", i, done[i], e_done);
        chk("busy", i, busy[i], e_busy);
        chk("IORQ_L", i, IORQ_L[i], e_io);
        chk("RD_L", i, RD_L[i], e_rd);
        chk("WR_L", i, WR_L[i], e_wr);
        chk("addr_oe", i, addr_oe[i], e_aoe);
        chk("data_oe", i, data_oe[i], e_doe);
        chk("rdata", i, rdata[i], m_rd[i]);
        if (e_aoe) chk("addr_out", i, addr_out[i], m_addr[i]);
        if (e_doe) chk("data_out", i, data_out[i], m_wd[i]);
        // advance to the next cycle using the inputs the coming edge will sample
        if (reset) begin
          m_act[i] = 0;
          m_rd[i]  = 8'h00;
        end else if (!m_act[i]) begin
          if (req[i]) begin
            m_act[i] = 1; m_fin[i] = 0; m_age[i] = 1; m_tw[i] = 0;
            m_we[i] = we[i]; m_addr[i] = port_addr[i]; m_wd[i] = wdata[i];
          end
        end else if (m_fin[i]) begin
          m_act[i] = 0;
        end else if (m_age[i] < 3) begin
          m_age[i]++;
          if (m_age[i] == 3) m_tw[i] = 1;
        end else if (m_tw[i] >= ws_of[i] && WAIT_L[i]) begin
          m_fin[i] = 1;
          if (!m_we[i]) m_rd[i] = data_in[i];
        end else begin
          m_tw[i]++;
        end
      end
    end
  end

  // Called at posedge+2 in an idle cycle; returns at posedge+2 of the following idle cycle.
  task automatic do_io(input int i, input bit w, input logic [15:0] a, input logic [7:0] d,
                       input logic [7:0] rv, input int k, input int exp_lat,
                       input int exp_strb, input string nm);
    int t, lat, nstr;
    bit got;
    req[i] = 1; we[i] = w; port_addr[i] = a; wdata[i] = d; data_in[i] = rv; WAIT_L[i] = 1;
    got = 0; t = 0;
    while (!got && t < 20) begin
      #1;
      if (ack[i] === 1'b1) got = 1;
      else begin @(posedge clk); #2; t++; end
    end
    chk({nm, "_ack"}, i, 32'(got), 1);
    @(posedge clk); #2;
    req[i] = 0;
    lat = 1; got = 0; nstr = 0;
    while (!got && lat < 40) begin
      WAIT_L[i]  = !(lat >= 3 && lat < 3 + k);
      data_in[i] = WAIT_L[i] ? rv : ~rv;
      #1;
      if (IORQ_L[i] === 1'b0) begin
        nstr++;
        chk({nm, "_addr"}, i, addr_out[i], a);
        chk({nm, "_doe"}, i, data_oe[i], 32'(w));
        if (w) chk({nm, "_dout"}, i, data_out[i], d);
      end
      if (done[i] === 1'b1) got = 1;
      else begin @(posedge clk); #2; lat++; end
    end
    chk({nm, "_lat"}, i, lat, exp_lat);
    chk({nm, "_strb"}, i, nstr, exp_strb);
    if (!w) chk({nm, "_rdata"}, i, rdata[i], rv);
    WAIT_L[i] = 1;
    @(posedge clk); #2;
  endtask

  initial begin
    int a0, a1, t;
    bit got;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; port_addr[i] = 0; wdata[i] = 0; data_in[i] = 0; WAIT_L[i] = 1;
    end
    repeat (2) @(posedge clk);
    #2;
    chk_on = 1;
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_rdata", 1, rdata[1], 8'h00);
    chk("rst_iorq", 0, IORQ_L[0], 1);
    @(posedge clk); #2;
    reset = 0;
    @(posedge clk); #2;

    do_io(0, 1, 16'h00BE, 8'hDD, 8'h00, 0, 4, 2, "wr_be");
    do_io(0, 0, 16'h00BF, 8'h00, 8'h5A, 0, 4, 2, "rd_bf");
    do_io(0, 0, 16'h00BE, 8'h00, 8'hC3, 3, 7, 5, "rd_wait");
    do_io(1, 1, 16'h007E, 8'h11, 8'h00, 0, 6, 4, "wr_ws3");

    // back-to-back: req held across a write then a read
    req[0] = 1; we[0] = 1; port_addr[0] = 16'h0040; wdata[0] = 8'h77; data_in[0] = 8'h99;
    got = 0; t = 0; a0 = 0;
    while (!got && t < 20) begin
      #1;
      if (ack[0] === 1'b1) begin got = 1; a0 = cyc; end
      else begin @(posedge clk); #2; t++; end
    end
    chk("b2b_ack1", 0, 32'(got), 1);
    @(posedge clk); #2;
    we[0] = 0; port_addr[0] = 16'h0041;
    got = 0; t = 0; a1 = 0;
    while (!got && t < 20) begin
      #1;
      if (ack[0] === 1'b1) begin got = 1; a1 = cyc; end
      else begin @(posedge clk); #2; t++; end
    end
    chk("b2b_ack2", 0, 32'(got), 1);
    chk("b2b_gap", 0, a1 - a0, 5);
    @(posedge clk); #2;
    req[0] = 0;
    repeat (6) @(posedge clk);
    #2;
    chk("b2b_rdata", 0, rdata[0], 8'h99);

    // reset in the middle of a stretched write
    req[0] = 1; we[0] = 1; port_addr[0] = 16'h0099; wdata[0] = 8'h42; WAIT_L[0] = 0;
    #1;
    chk("rsttw_ack", 0, ack[0], 1);
    repeat (3) begin @(posedge clk); #2; req[0] = 0; end
    #1;
    chk("rsttw_in_tw", 0, WR_L[0], 0);
    #0 reset = 1;
    @(posedge clk); #1;
    chk("rsttw_busy", 0, busy[0], 0);
    chk("rsttw_strb", 0, {29'd0, IORQ_L[0], RD_L[0], WR_L[0]}, 3'b111);
    chk("rsttw_oe", 0, {30'd0, addr_oe[0], data_oe[0]}, 0);
    #1;
    reset = 0; WAIT_L[0] = 1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("rsttw_nodone", 0, done[0], 0);
      #1;
    end

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++) begin
        req[i]       = ($urandom_range(0, 2) != 0);
        we[i]        = $urandom_range(0, 1);
        port_addr[i] = 16'($urandom);
        wdata[i]     = 8'($urandom);
        data_in[i]   = 8'($urandom);
        WAIT_L[i]    = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #2;
    end
    reset = 0;
    for (int i = 0; i < 2; i++) begin req[i] = 0; WAIT_L[i] = 1; end
    repeat (12) @(posedge clk);
    #2;
    chk("end_idle0", 0, busy[0], 0);
    chk("end_idle1", 1, busy[1], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/z80_io_ctrl.md
Z80_IO_CTRL -- requirements
Module: z80_io_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, number of automatic TW cycles per I/O cycle (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 1, requester asks for one I/O cycle.
REQ-005 SHALL have port we, input, 1, 1 = OUT (write), 0 = IN (read); sampled with req.
REQ-006 SHALL have port port_addr, input, 16, I/O port address; sampled with req.
REQ-007 SHALL have port wdata, input, 8, write data; sampled with req.
REQ-008 SHALL have port ack, output, 1, one-cycle pulse: request accepted.
REQ-009 SHALL have port done, output, 1, one-cycle pulse: cycle complete (rdata valid for reads).
REQ-010 SHALL have port rdata, output, 8, read data captured from the bus.
REQ-011 SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-012 SHALL have port addr_out, output, 16, address bus drive value.
REQ-013 SHALL have port addr_oe, output, 1, address bus drive enable.
REQ-014 SHALL have port data_out, output, 8, data bus drive value.
REQ-015 SHALL have port data_oe, output, 1, data bus drive enable (writes only).
REQ-016 SHALL have port data_in, input, 8, data bus sampled value.
REQ-017 SHALL have ports IORQ_L, RD_L, WR_L, output, 1 each, active-low bus strobes.
REQ-018 SHALL have port WAIT_L, input, 1, active-low wait request from the peripheral (VDP etc.).

Function
REQ-019 SHALL implement FSM states IDLE, T1, T2, TW, T3; all bus outputs registered.
REQ-020 IDLE: req=1 -> ack=1 same cycle (combinational from IDLE&req), latch we/port_addr/wdata, next state T1.
REQ-021 T1: addr_oe=1, addr_out=latched address; data_oe=we with data_out=latched wdata; all strobes high; next T2.
REQ-022 T2: IORQ_L=0; RD_L=0 if read, WR_L=0 if write; address/data held; next TW, wait counter loaded with WAIT_STATES-1.
REQ-023 TW: strobes held low; leave TW only when counter==0 and WAIT_L=1 on that edge; otherwise decrement counter (saturating at 0) and stay.
REQ-024 Read: rdata SHALL be loaded from data_in on the edge leaving TW; rdata otherwise holds its value.
REQ-025 T3: IORQ_L/RD_L/WR_L=1; address and data still driven; done=1; next IDLE.
REQ-026 Back-to-back: req in T3 is NOT acked; earliest ack is the following IDLE cycle, giving minimum 5-cycle spacing between acks with WAIT_STATES=1.
REQ-027 req while busy SHALL be ignored (no ack, no latch); requester holds req until ack.
REQ-028 IDLE: addr_oe=0, data_oe=0, strobes high, done=0.
REQ-029 Latency with WAIT_STATES=N and no WAIT_L: ack to done = 3+N cycles; WAIT_L low for k TW edges adds k cycles.
REQ-030 RD_L and WR_L SHALL never be low simultaneously; data_oe SHALL never be high during a read.

Reset
REQ-031 reset=1 at any state (incl. mid-T2/TW) SHALL on that edge force IDLE, IORQ_L/RD_L/WR_L=1, addr_oe=data_oe=0, ack=done=busy=0, rdata=8'h00, addr_out=16'h0000, data_out=8'h00, counter=0; no done for the aborted cycle.

Structure
REQ-032 Package z80_io_pkg SHALL hold typedef io_state_t (IDLE,T1,T2,TW,T3) and constant IO_WAIT_MAX=7.
REQ-033 Single module, no sub-module; wait counter 3 bits inline.

Verification
REQ-034 Write 8'hDD to 16'h00BE, WAIT_L=1 -> T2..TW: IORQ_L=WR_L=0, RD_L=1, addr_out=00BE, data_out=DD, data_oe=1; done 4 cycles after ack.
REQ-035 Read 16'h00BF, bus model returns 8'h5A -> RD_L=0, data_oe=0, rdata=5A with done.
REQ-036 Read 16'h00BE, WAIT_L low for 3 edges in TW -> done 7 cycles after ack; rdata sampled after WAIT_L release.
REQ-037 req held continuously for write then read -> second ack exactly 5 cycles after first; strobes high for at least 2 cycles between cycles (T3, IDLE).
REQ-038 reset asserted during TW of a write -> next cycle all strobes high, oe low, busy=0, no done pulse.
REQ-039 WAIT_STATES=3, write 8'h11 to 16'h007E -> strobes low 4 cycles, done 6 cycles after ack.
